// File: rtl/exe_stage.sv
// Execute stage: one-hot ALU, load/store request with byte strobes, single-cycle
// multiplier and iterative restoring divider. ES_DIV_ZERO_FAST_EN skips the divide loop on a zero divisor.
`ifndef DS_TO_ES_BUS_WD
`define DS_TO_ES_BUS_WD 156
`endif
`ifndef ES_TO_MS_BUS_WD
`define ES_TO_MS_BUS_WD 79
`endif
`ifndef ES_TO_DS_BUS_WD
`define ES_TO_DS_BUS_WD 39
`endif

module exe_stage #(
    parameter int DIV_ITERS = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ms_allowin,
    output logic                         es_allowin,
    input  logic                         ds_to_es_valid,
    input  logic [`DS_TO_ES_BUS_WD-1:0]  ds_to_es_bus,
    output logic                         es_to_ms_valid,
    output logic [`ES_TO_MS_BUS_WD-1:0]  es_to_ms_bus,
    output logic [`ES_TO_DS_BUS_WD-1:0]  es_to_ds_forward_bus,
    output logic                         data_sram_en,
    output logic [3:0]                   data_sram_we,
    output logic [31:0]                  data_sram_addr,
    output logic [31:0]                  data_sram_wdata,
    output logic [63:0]                  mul_result,
    output logic [31:0]                  div_result,
    output logic [31:0]                  mod_result
);
    localparam int CNT_W = $clog2(DIV_ITERS + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

    logic                         es_valid_reg;
    logic [`DS_TO_ES_BUS_WD-1:0]  bus_reg;
    logic                         es_ready_go;
    logic                         handoff;

    logic [11:0] alu_op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] st_data;
    logic [3:0]  mul_div_op;
    logic        mul_div_signed;
    logic        mem_sign_ext;
    logic [1:0]  mem_size;
    logic        store_op;
    logic        load_op;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] pc;

    assign {alu_op, src1, src2, st_data, mul_div_op, mul_div_signed, mem_sign_ext,
            mem_size, store_op, load_op, gr_we, dest, pc} = bus_reg;

    logic is_div;
    logic is_mul;
    assign is_div = |mul_div_op[3:2];
    assign is_mul = |mul_div_op[1:0];

    // ---------------- handshake and bus latch ----------------
    assign es_allowin     = !es_valid_reg | (es_ready_go & ms_allowin);
    assign es_to_ms_valid = es_valid_reg & es_ready_go;
    assign handoff        = es_to_ms_valid & ms_allowin;

    always_ff @(posedge clk) begin
        if (reset) begin
            es_valid_reg <= 1'b0;
        end else if (es_allowin) begin
            es_valid_reg <= ds_to_es_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (ds_to_es_valid & es_allowin) begin
            bus_reg <= ds_to_es_bus;
        end
    end

    // ---------------- ALU ----------------
    logic [31:0] op_res    [12];
    logic [31:0] op_masked [12];
    logic [31:0] alu_result;

    always_comb begin
        op_res[0]  = src1 + src2;
        op_res[1]  = src1 - src2;
        op_res[2]  = {31'b0, $signed(src1) < $signed(src2)};
        op_res[3]  = {31'b0, src1 < src2};
        op_res[4]  = src1 & src2;
        op_res[5]  = ~(src1 | src2);
        op_res[6]  = src1 | src2;
        op_res[7]  = src1 ^ src2;
        op_res[8]  = src1 << src2[4:0];
        op_res[9]  = src1 >> src2[4:0];
        op_res[10] = 32'($signed(src1) >>> src2[4:0]);
        op_res[11] = src2;
    end

    generate
        for (genvar gi = 0; gi < 12; gi++) begin : g_alu_sel
            assign op_masked[gi] = op_res[gi] & {32{alu_op[gi]}};
        end
    endgenerate

    always_comb begin
        alu_result = '0;
        for (int i = 0; i < 12; i++) begin
            alu_result = alu_result | op_masked[i];
        end
    end

    // ---------------- multiplier ----------------
    // Low 64 bits of the 33x33 product equal the low 64 bits of a 64x64 product
    // of the same extended operands.
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] mul_prod;
    assign mul_a    = {{32{mul_div_signed & src1[31]}}, src1};
    assign mul_b    = {{32{mul_div_signed & src2[31]}}, src2};
    assign mul_prod = mul_a * mul_b;

    // ---------------- divider ----------------
    div_state_t       state_reg;
    div_state_t       state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [31:0]      quo_reg;
    logic [31:0]      rem_reg;
    logic [31:0]      dvsr_reg;
    logic             q_neg_reg;
    logic             r_neg_reg;
    logic             dvsr_zero_reg;

    logic        div_start;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [32:0] shifted;
    logic [32:0] diff;
    logic [31:0] q_final;
    logic [31:0] r_final;

    assign div_start = es_valid_reg & is_div & (state_reg == IDLE);
    assign a_neg     = mul_div_signed & src1[31];
    assign b_neg     = mul_div_signed & src2[31];
    assign abs_a     = a_neg ? -src1 : src1;
    assign abs_b     = b_neg ? -src2 : src2;
    assign shifted   = {rem_reg, quo_reg[31]};
    assign diff      = shifted - {1'b0, dvsr_reg};
    assign q_final   = dvsr_zero_reg ? 32'hFFFF_FFFF : (q_neg_reg ? -quo_reg : quo_reg);
    assign r_final   = r_neg_reg ? -rem_reg : rem_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (div_start) begin
`ifdef ES_DIV_ZERO_FAST_EN
                    state_next = (src2 == 32'b0) ? DONE : BUSY;
`else
                    state_next = BUSY;
`endif
                end
            end
            BUSY: begin
                if (cnt_reg == CNT_W'(1)) state_next = DONE;
            end
            DONE: begin
                if (handoff) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        es_ready_go = is_div ? (state_reg == DONE) : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg       <= '0;
            quo_reg       <= '0;
            rem_reg       <= '0;
            dvsr_reg      <= '0;
            q_neg_reg     <= 1'b0;
            r_neg_reg     <= 1'b0;
            dvsr_zero_reg <= 1'b0;
        end else if (state_reg == IDLE && div_start) begin
            quo_reg       <= abs_a;
            rem_reg       <= '0;
            dvsr_reg      <= abs_b;
            q_neg_reg     <= a_neg ^ b_neg;
            r_neg_reg     <= a_neg;
            dvsr_zero_reg <= (src2 == 32'b0);
            cnt_reg       <= CNT_W'(DIV_ITERS);
`ifdef ES_DIV_ZERO_FAST_EN
            // Remainder of a divide by zero is the dividend; preload it since no steps run.
            if (src2 == 32'b0) begin
                rem_reg <= abs_a;
                cnt_reg <= '0;
            end
`endif
        end else if (state_reg == BUSY) begin
            quo_reg <= {quo_reg[30:0], ~diff[32]};
            rem_reg <= diff[32] ? shifted[31:0] : diff[31:0];
            cnt_reg <= cnt_reg - CNT_W'(1);
        end
    end

    // ---------------- result registers seen by ms ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            mul_result <= '0;
            div_result <= '0;
            mod_result <= '0;
        end else begin
            if (handoff & is_mul) begin
                mul_result <= mul_prod;
            end
            if (handoff & is_div) begin
                div_result <= q_final;
                mod_result <= r_final;
            end
        end
    end

    // ---------------- SRAM request ----------------
    logic [3:0] we_raw;

    assign data_sram_en   = es_valid_reg & ms_allowin & (load_op | store_op) & es_ready_go;
    assign data_sram_addr = alu_result;

    always_comb begin
        we_raw          = 4'b1111;
        data_sram_wdata = st_data;
        case (mem_size)
            2'b01: begin
                we_raw          = 4'b0001 << alu_result[1:0];
                data_sram_wdata = {4{st_data[7:0]}};
            end
            2'b10: begin
                we_raw          = alu_result[1] ? 4'b1100 : 4'b0011;
                data_sram_wdata = {2{st_data[15:0]}};
            end
            default: begin
                we_raw          = 4'b1111;
                data_sram_wdata = st_data;
            end
        endcase
    end

    assign data_sram_we = (store_op & data_sram_en) ? we_raw : 4'b0000;

    // ---------------- output buses ----------------
    logic forward_enable;
    logic dep_need_stall;
    assign forward_enable = es_valid_reg & gr_we & (dest != 5'd0);
    assign dep_need_stall = load_op | (mul_div_op != 4'b0);

    assign es_to_ms_bus = {mem_sign_ext, store_op, mem_size, mul_div_op, load_op, gr_we,
                           dest, alu_result, pc};
    assign es_to_ds_forward_bus = {dep_need_stall, forward_enable, dest, alu_result};

endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: expectations queued at issue, compared at ms handoff.
// Divide-by-zero latency follows ES_DIV_ZERO_FAST_EN when defined for the build.
module tb_exe_stage;
    logic         clk = 1'b0;
    logic         reset;
    logic         ms_allowin;
    logic         es_allowin;
    logic         ds_to_es_valid;
    logic [155:0] ds_to_es_bus;
    logic         es_to_ms_valid;
    logic [78:0]  es_to_ms_bus;
    logic [38:0]  es_to_ds_forward_bus;
    logic         data_sram_en;
    logic [3:0]   data_sram_we;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;
    logic [63:0]  mul_result;
    logic [31:0]  div_result;
    logic [31:0]  mod_result;

    exe_stage dut (
        .clk                  (clk),
        .reset                (reset),
        .ms_allowin           (ms_allowin),
        .es_allowin           (es_allowin),
        .ds_to_es_valid       (ds_to_es_valid),
        .ds_to_es_bus         (ds_to_es_bus),
        .es_to_ms_valid       (es_to_ms_valid),
        .es_to_ms_bus         (es_to_ms_bus),
        .es_to_ds_forward_bus (es_to_ds_forward_bus),
        .data_sram_en         (data_sram_en),
        .data_sram_we         (data_sram_we),
        .data_sram_addr       (data_sram_addr),
        .data_sram_wdata      (data_sram_wdata),
        .mul_result           (mul_result),
        .div_result           (div_result),
        .mod_result           (mod_result)
    );

    always #5 clk = ~clk;

    localparam logic [11:0] OP_ADD = 12'h001, OP_SUB = 12'h002, OP_SLT = 12'h004,
                            OP_SLTU = 12'h008, OP_AND = 12'h010, OP_NOR = 12'h020,
                            OP_OR = 12'h040, OP_XOR = 12'h080, OP_SLL = 12'h100,
                            OP_SRL = 12'h200, OP_SRA = 12'h400, OP_LUI = 12'h800;

`ifdef ES_DIV_ZERO_FAST_EN
    localparam int DIV0_LAT = 1;
`else
    localparam int DIV0_LAT = 33;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [31:0] res;
        int          issue;
        int          lat;
        int          kind;   // 0 plain, 1 mul, 2 div/mod
        logic [63:0] mul;
        logic [31:0] q;
        logic [31:0] r;
    } exp_t;

    exp_t sb[$];
    exp_t pend;
    exp_t mon_e;
    bit   pend_v = 0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [155:0] mk_bus(input logic [11:0] aop, input logic [31:0] s1,
            input logic [31:0] s2, input logic [31:0] sd, input logic [3:0] mdo,
            input logic sg, input logic [1:0] sz, input logic st, input logic ld,
            input logic we, input logic [4:0] dst, input logic [31:0] pc);
        return {aop, s1, s2, sd, mdo, sg, 1'b0, sz, st, ld, we, dst, pc};
    endfunction

    function automatic exp_t mk_exp(input logic [31:0] pc, input logic [31:0] res, input int lat,
            input int kind, input logic [63:0] mul, input logic [31:0] q, input logic [31:0] r);
        exp_t e;
        e.pc = pc; e.res = res; e.issue = 0; e.lat = lat; e.kind = kind;
        e.mul = mul; e.q = q; e.r = r;
        return e;
    endfunction

    function automatic logic [63:0] mul_model(input logic [31:0] a, input logic [31:0] b, input bit s);
        longint sa, sbv;
        if (s) begin
            sa  = longint'($signed(a));
            sbv = longint'($signed(b));
            return 64'(sa * sbv);
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    task automatic div_model(input logic [31:0] a, input logic [31:0] b, input bit s,
                             output logic [31:0] q, output logic [31:0] r);
        if (b == 0) begin
            q = 32'hFFFF_FFFF; r = a;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; r = 0;
        end else if (s) begin
            q = 32'($signed(a) / $signed(b));
            r = 32'($signed(a) % $signed(b));
        end else begin
            q = a / b; r = a % b;
        end
    endtask

    // Drive one instruction for one cycle once ES can take it; returns at the negedge
    // of the cycle in which the instruction sits in ES.
    task automatic issue(input logic [155:0] bus, input exp_t e);
        int n = 0;
        while (!es_allowin && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!es_allowin) check_val("allowin_timeout", 0, 1);
        ds_to_es_bus   = bus;
        ds_to_es_valid = 1'b1;
        e.issue = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        ds_to_es_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || pend_v) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_val("drain_done", (sb.size() == 0 && !pend_v), 1);
    endtask

    always @(negedge clk) begin
        if (pend_v) begin
            pend_v = 0;
            if (pend.kind == 1) begin
                check_val("mul_result", mul_result, pend.mul);
            end else begin
                check_val("div_result", div_result, pend.q);
                check_val("mod_result", mod_result, pend.r);
            end
        end
        if (!reset && es_to_ms_valid && ms_allowin) begin
            if (sb.size() == 0) begin
                check_val("unexpected_handoff", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                $display("txn pc=%08h result=%08h latency=%0d", es_to_ms_bus[31:0],
                         es_to_ms_bus[63:32], cyc - mon_e.issue);
                check_val("ms_pc", es_to_ms_bus[31:0], mon_e.pc);
                check_val("ms_exe_result", es_to_ms_bus[63:32], mon_e.res);
                check_val("latency", cyc - mon_e.issue, mon_e.lat);
                if (mon_e.kind != 0) begin
                    pend   = mon_e;
                    pend_v = 1;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    typedef struct { logic [11:0] op; logic [31:0] a; logic [31:0] b; logic [31:0] res; } alu_vec_t;
    typedef struct { logic [31:0] base; logic [31:0] off; logic [1:0] sz; logic [31:0] sd;
                     logic [3:0] we; logic [31:0] wd; } st_vec_t;
    typedef struct { logic [31:0] a; logic [31:0] b; bit s; logic [3:0] op; } md_vec_t;

    alu_vec_t alu_tbl[11];
    st_vec_t  st_tbl[4];
    md_vec_t  mul_tbl[4];
    md_vec_t  div_tbl[6];

    initial begin
        logic [31:0] q;
        logic [31:0] r;
        logic [31:0] pc;

        alu_tbl = '{
            '{OP_SUB,  32'd3,          32'd10,         32'hFFFF_FFF9},
            '{OP_SLT,  32'hFFFF_FFFF,  32'd1,          32'd1},
            '{OP_SLTU, 32'hFFFF_FFFF,  32'd1,          32'd0},
            '{OP_AND,  32'hF0F0_1234,  32'h0FF0_FF00,  32'h00F0_1200},
            '{OP_NOR,  32'hF0F0_0000,  32'h0F00_00FF,  32'h000F_FF00},
            '{OP_OR,   32'hF000_0001,  32'h0000_0010,  32'hF000_0011},
            '{OP_XOR,  32'hAAAA_5555,  32'hFFFF_0000,  32'h5555_5555},
            '{OP_SLL,  32'h0000_0001,  32'h0000_0021,  32'h0000_0002},
            '{OP_SRL,  32'h8000_0000,  32'd4,          32'h0800_0000},
            '{OP_SRA,  32'h8000_0000,  32'd4,          32'hF800_0000},
            '{OP_LUI,  32'h1234_5678,  32'hABCD_0000,  32'hABCD_0000}};
        st_tbl = '{
            '{32'h1000, 32'd3, 2'b01, 32'h0000_00A5, 4'b1000, 32'hA5A5_A5A5},
            '{32'h1000, 32'd2, 2'b10, 32'h0000_1234, 4'b1100, 32'h1234_1234},
            '{32'h2000, 32'd0, 2'b00, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF},
            '{32'h1000, 32'd0, 2'b01, 32'h0000_003C, 4'b0001, 32'h3C3C_3C3C}};
        mul_tbl = '{
            '{32'hFFFF_FFFF, 32'd2,          1'b1, 4'b0001},
            '{32'hFFFF_FFFF, 32'd2,          1'b0, 4'b0001},
            '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 4'b0010},
            '{32'h8000_0000, 32'h8000_0000, 1'b1, 4'b0001}};
        div_tbl = '{
            '{32'hFFFF_FFF9, 32'd2,          1'b1, 4'b0100},
            '{32'd9,         32'd0,          1'b0, 4'b0100},
            '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 4'b0100},
            '{32'd100,       32'd7,          1'b0, 4'b1000},
            '{32'd7,         32'hFFFF_FFFE, 1'b1, 4'b1000},
            '{32'hFFFF_FFF7, 32'd0,          1'b1, 4'b0100}};

        reset = 1'b1; ms_allowin = 1'b1; ds_to_es_valid = 1'b0; ds_to_es_bus = '0;
        repeat (3) @(negedge clk);
        check_val("rst_es_to_ms_valid", es_to_ms_valid, 0);
        check_val("rst_es_allowin", es_allowin, 1);
        check_val("rst_sram_en", data_sram_en, 0);
        check_val("rst_sram_we", data_sram_we, 0);
        check_val("rst_fwd_enable", es_to_ds_forward_bus[37], 0);
        check_val("rst_mul_result", mul_result, 0);
        check_val("rst_div_result", div_result, 0);
        check_val("rst_mod_result", mod_result, 0);
        reset = 1'b0;
        @(negedge clk);

        // add with forwarding
        issue(mk_bus(OP_ADD, 32'd5, 32'd7, 0, 4'b0, 0, 2'b00, 0, 0, 1, 5'd3, 32'h100),
              mk_exp(32'h100, 32'd12, 0, 0, 0, 0, 0));
        check_val("fwd_enable", es_to_ds_forward_bus[37], 1);
        check_val("fwd_dep_stall", es_to_ds_forward_bus[38], 0);
        check_val("fwd_dest", es_to_ds_forward_bus[36:32], 5'd3);
        check_val("fwd_value", es_to_ds_forward_bus[31:0], 32'd12);
        check_val("add_sram_en", data_sram_en, 0);

        // ALU ops back to back
        for (int i = 0; i < 11; i++) begin
            pc = 32'h200 + 32'(i * 4);
            issue(mk_bus(alu_tbl[i].op, alu_tbl[i].a, alu_tbl[i].b, 0, 4'b0, 0, 2'b00, 0, 0, 1,
                         5'd0, pc), mk_exp(pc, alu_tbl[i].res, 0, 0, 0, 0, 0));
            check_val("fwd_dest0_disabled", es_to_ds_forward_bus[37], 0);
        end
        drain();

        // stores: strobes and replicated data
        for (int i = 0; i < 4; i++) begin
            pc = 32'h300 + 32'(i * 4);
            issue(mk_bus(OP_ADD, st_tbl[i].base, st_tbl[i].off, st_tbl[i].sd, 4'b0, 0,
                         st_tbl[i].sz, 1, 0, 0, 5'd0, pc),
                  mk_exp(pc, st_tbl[i].base + st_tbl[i].off, 0, 0, 0, 0, 0));
            check_val("st_sram_en", data_sram_en, 1);
            check_val("st_sram_addr", data_sram_addr, st_tbl[i].base + st_tbl[i].off);
            check_val("st_sram_we", data_sram_we, st_tbl[i].we);
            check_val("st_sram_wdata", data_sram_wdata, st_tbl[i].wd);
        end
        drain();

        // load: request without strobes, load-use stall flag
        issue(mk_bus(OP_ADD, 32'h3000, 32'd4, 0, 4'b0, 0, 2'b00, 0, 1, 1, 5'd9, 32'h400),
              mk_exp(32'h400, 32'h3004, 0, 0, 0, 0, 0));
        check_val("ld_sram_en", data_sram_en, 1);
        check_val("ld_sram_we", data_sram_we, 0);
        check_val("ld_dep_stall", es_to_ds_forward_bus[38], 1);
        drain();

        // store while ms is back-pressuring: no request until ms_allowin rises
        ms_allowin = 1'b0;
        issue(mk_bus(OP_ADD, 32'h1000, 32'd1, 32'h77, 4'b0, 0, 2'b01, 1, 0, 0, 5'd0, 32'h500),
              mk_exp(32'h500, 32'h1001, 0, 0, 0, 0, 0));
        check_val("bp_sram_en", data_sram_en, 0);
        check_val("bp_sram_we", data_sram_we, 0);
        check_val("bp_es_allowin", es_allowin, 0);
        check_val("bp_es_to_ms_valid", es_to_ms_valid, 1);
        ms_allowin = 1'b1;
        #1;
        check_val("bp_release_sram_en", data_sram_en, 1);
        check_val("bp_release_sram_we", data_sram_we, 4'b0010);
        void'(sb.pop_front());
        @(negedge clk);

        // multiplies
        for (int i = 0; i < 4; i++) begin
            pc = 32'h600 + 32'(i * 4);
            issue(mk_bus(OP_ADD, mul_tbl[i].a, mul_tbl[i].b, 0, mul_tbl[i].op, mul_tbl[i].s,
                         2'b00, 0, 0, 1, 5'd4, pc),
                  mk_exp(pc, mul_tbl[i].a + mul_tbl[i].b, 0, 1,
                         mul_model(mul_tbl[i].a, mul_tbl[i].b, mul_tbl[i].s), 0, 0));
            check_val("mul_dep_stall", es_to_ds_forward_bus[38], 1);
        end
        drain();

        // divides, issued back to back so ES stalls between them
        for (int i = 0; i < 6; i++) begin
            pc = 32'h700 + 32'(i * 4);
            div_model(div_tbl[i].a, div_tbl[i].b, div_tbl[i].s, q, r);
            issue(mk_bus(OP_ADD, div_tbl[i].a, div_tbl[i].b, 0, div_tbl[i].op, div_tbl[i].s,
                         2'b00, 0, 0, 1, 5'd5, pc),
                  mk_exp(pc, div_tbl[i].a + div_tbl[i].b,
                         (div_tbl[i].b == 0) ? DIV0_LAT : 33, 2, 0, q, r));
            if (div_tbl[i].b != 0) check_val("div_not_ready", es_to_ms_valid, 0);
        end
        drain();

        // reset in the middle of a divide
        issue(mk_bus(OP_ADD, 32'd100, 32'hFFFF_FFFD, 0, 4'b0100, 1, 2'b00, 0, 0, 1, 5'd6, 32'h800),
              mk_exp(32'h800, 32'd97, 33, 2, 0, 0, 0));
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_val("midrst_es_to_ms_valid", es_to_ms_valid, 0);
        check_val("midrst_es_allowin", es_allowin, 1);
        check_val("midrst_div_result", div_result, 0);
        check_val("midrst_mod_result", mod_result, 0);
        check_val("midrst_mul_result", mul_result, 0);
        sb.delete();
        reset = 1'b0;
        @(negedge clk);
        div_model(32'd100, 32'hFFFF_FFFD, 1'b1, q, r);
        issue(mk_bus(OP_ADD, 32'd100, 32'hFFFF_FFFD, 0, 4'b0100, 1, 2'b00, 0, 0, 1, 5'd6, 32'h804),
              mk_exp(32'h804, 32'd97, 33, 2, 0, q, r));
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
